rf_wport_arbiter: RTL
=====================

Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between two sources.
- The W-stage pipeline write has fixed priority and is never delayed.
- A long-latency source (multi-cycle MDU / delayed load return) is buffered in a small FIFO and drained into idle write-port cycles.
- Also provides scoreboard lookups so D-stage hazard logic can stall readers of registers with queued writes, plus a starvation stall request and a WAW-conflict error flag.

Parameters:
DEPTH, 4, long-write FIFO entries (power of two, 2..8)
STARVE, 8, cycles the FIFO head may wait before stall_req asserts (1..255)

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
pipe_we  in  1  W-stage write enable
pipe_a3  in  5  W-stage destination register
pipe_wd  in  32  W-stage write data
pipe_pc  in  32  W-stage instruction PC (trace)
lng_valid  in  1  long-source write request
lng_ready  out  1  FIFO can accept (= !full)
lng_a3  in  5  long-source destination
lng_wd  in  32  long-source data
lng_pc  in  32  long-source PC
rf_we  out  1  to regfile WE
rf_a3  out  5  to regfile A3
rf_wd  out  32  to regfile WD
rf_pc  out  32  to regfile TPC
q1  in  5  scoreboard query address 1 (rs)
q2  in  5  scoreboard query address 2 (rt)
busy1  out  1  q1 has a queued long write
busy2  out  1  q2 has a queued long write
stall_req  out  1  request pipeline bubble so the FIFO head can drain
waw_err  out  1  sticky: pipe wrote a register with a queued long write
fifo_cnt  out  4  current FIFO occupancy (0..DEPTH)

Behaviour:
Reset:
- reset=1 asynchronously empties the FIFO (count 0, pointers 0), clears the wait counter and clears waw_err.
- Reset values: lng_ready=1, rf_we=pipe_we, busy1=busy2=0, stall_req=0, fifo_cnt=0.
- An asserted reset discards queued entries mid-operation; nothing pending is written afterwards.

Accept:
- Handshake fires when lng_valid && lng_ready at the clk edge; the entry {a3,wd,pc} is pushed at the tail.
- If lng_a3==0 the handshake completes but nothing is enqueued (writes to $0 are dropped).
- lng_ready = (fifo_cnt != DEPTH). It depends only on state, not on the same-cycle pop, so a full FIFO does not accept even when it is popping.

Grant (combinational):
- If pipe_we=1: rf_we=1, rf_a3/wd/pc = pipe_*. The FIFO holds. pipe_a3==0 is passed through unchanged; the regfile ignores it.
- Else if the FIFO is non-empty: rf_we=1, rf_* = head entry, and the head pops at the next clk edge.
- Else: rf_we=0, rf_a3=0, rf_wd=0, rf_pc=0.

Push and pop:
- Simultaneous push and pop in one cycle: count is unchanged, and the head advances before the new tail is visible.
- Pointers wrap modulo DEPTH.
- An entry pushed at edge N is grantable from cycle N+1; there is no same-cycle bypass.

Scoreboard:
- busyK = 1 iff any valid FIFO entry has a3 == qK and qK != 0. Combinational, evaluated on the current FIFO contents.
- The entry popping this cycle still counts as busy in this cycle.

Starvation:
- The wait counter increments each cycle the FIFO is non-empty and the head is not granted.
- It clears on any pop and when the FIFO is empty; it saturates at STARVE.
- stall_req = (counter == STARVE). Upstream responds by issuing pipe_we=0; the head then pops and stall_req drops the next cycle.

WAW check:
- If pipe_we && pipe_a3!=0 && pipe_a3 matches any valid FIFO entry at a clk edge, waw_err is set and held until reset.
- The write still proceeds.
- Hazard logic must prevent this case using busy1/busy2.

Ordering:
- Long writes retire in FIFO order.
- Relative to each other, pipe writes retire in their issue cycle.

Test Plan:
1. Reset with pipe_we=0, lng_valid=0 -> rf_we=0, lng_ready=1, fifo_cnt=0, busy1=busy2=0, waw_err=0.
2. pipe_we=1 (a3=5, wd=0x11) in the same cycle as lng_valid=1 (a3=7, wd=0x22) -> rf_a3=5, wd=0x11 that cycle. Next cycle with pipe_we=0 -> rf_a3=7, wd=0x22 (trace pc passes through), fifo_cnt returns to 0.
3. Hold pipe_we=1 and push 4 entries (a3=1..4) -> fifo_cnt=4, lng_ready=0, a 5th push is refused. With q1=3: busy1=1. With q1=0: busy1=0.
4. Continue pipe_we=1 with FIFO non-empty for STARVE=8 cycles -> stall_req=1 on the 8th cycle. Drop pipe_we for one cycle -> head a3=1 written, stall_req=0 next cycle.
5. Queue a3=9, then pipe_we=1 with pipe_a3=9 -> waw_err=1 and stays 1. Assert reset mid-queue -> FIFO empty, no write to $9 follows, waw_err=0.
6. lng_a3=0 handshake -> fifo_cnt unchanged, no rf write. Push/pop 10 entries with alternating pipe_we to exercise pointer wrap -> writes appear in exact push order.

Source files
------------

// File: rtl/rf_wport_arbiter_if.sv
// Register-file write-port bundle: pipeline write, long-latency write request,
// arbitrated regfile write, and scoreboard/status signals.
interface rf_wport_if;
  logic        pipe_we;
  logic [4:0]  pipe_a3;
  logic [31:0] pipe_wd;
  logic [31:0] pipe_pc;

  logic        lng_valid;
  logic        lng_ready;
  logic [4:0]  lng_a3;
  logic [31:0] lng_wd;
  logic [31:0] lng_pc;

  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [31:0] rf_pc;

  logic [4:0]  q1;
  logic [4:0]  q2;
  logic        busy1;
  logic        busy2;
  logic        stall_req;
  logic        waw_err;
  logic [3:0]  fifo_cnt;

  modport master (
    output pipe_we, pipe_a3, pipe_wd, pipe_pc,
    output lng_valid, lng_a3, lng_wd, lng_pc,
    output q1, q2,
    input  lng_ready, rf_we, rf_a3, rf_wd, rf_pc,
    input  busy1, busy2, stall_req, waw_err, fifo_cnt
  );

  modport slave (
    input  pipe_we, pipe_a3, pipe_wd, pipe_pc,
    input  lng_valid, lng_a3, lng_wd, lng_pc,
    input  q1, q2,
    output lng_ready, rf_we, rf_a3, rf_wd, rf_pc,
    output busy1, busy2, stall_req, waw_err, fifo_cnt
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Shares the regfile write port: W-stage writes win, long-latency writes queue
// in a small FIFO and drain into idle cycles, with scoreboard and starvation stall.
module rf_wport_arbiter #(
  parameter int DEPTH  = 4,
  parameter int STARVE = 8
) (
  input logic      clk,
  input logic      reset,
  rf_wport_if.slave bus
);
  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C  = 4'(DEPTH);
  localparam logic [7:0] STARVE_C = 8'(STARVE);

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [3:0]       cnt;
  logic [7:0]       wait_cnt;
  logic             waw_q;

  logic full, empty, push, pop, waw_hit;

  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == 4'd0);
  // $0 requests complete the handshake but are never queued.
  assign push  = bus.lng_valid && !full && (bus.lng_a3 != 5'd0);
  assign pop   = !bus.pipe_we && !empty;

  assign bus.lng_ready = !full;
  assign bus.fifo_cnt  = cnt;
  assign bus.stall_req = (wait_cnt == STARVE_C);
  assign bus.waw_err   = waw_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    bus.busy1 = 1'b0;
    bus.busy2 = 1'b0;
    waw_hit   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) begin
        if (mem[i].a3 == bus.q1      && bus.q1      != 5'd0) bus.busy1 = 1'b1;
        if (mem[i].a3 == bus.q2      && bus.q2      != 5'd0) bus.busy2 = 1'b1;
        if (mem[i].a3 == bus.pipe_a3 && bus.pipe_a3 != 5'd0) waw_hit  = 1'b1;
      end
    end
  end

  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_a3 = 5'd0;
    bus.rf_wd = 32'd0;
    bus.rf_pc = 32'd0;
    if (bus.pipe_we) begin
      bus.rf_we = 1'b1;
      bus.rf_a3 = bus.pipe_a3;
      bus.rf_wd = bus.pipe_wd;
      bus.rf_pc = bus.pipe_pc;
    end else if (!empty) begin
      bus.rf_we = 1'b1;
      bus.rf_a3 = mem[rd_ptr].a3;
      bus.rf_wd = mem[rd_ptr].wd;
      bus.rf_pc = mem[rd_ptr].pc;
    end
  end

  // NOTE: storage carries no reset; the valid bits and count alone define what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a3: bus.lng_a3, wd: bus.lng_wd, pc: bus.lng_pc};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= 4'd0;
      wait_cnt <= 8'd0;
      waw_q    <= 1'b0;
    end else begin
      // Push and pop never target the same slot: pop needs non-empty, push needs non-full.
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= AW'(rd_ptr + 1'b1);
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= AW'(wr_ptr + 1'b1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
      if (empty || pop)              wait_cnt <= 8'd0;
      else if (wait_cnt != STARVE_C) wait_cnt <= wait_cnt + 8'd1;
      if (bus.pipe_we && waw_hit) waw_q <= 1'b1;
    end
  end
endmodule
